// File: rtl/timer_pkg.sv
// Shared types for the timer family: state encoding and a small state query helper.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_e;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    // IDLE and DONE are functionally identical; only RUN counts as busy.
    function automatic logic is_idle_like(timer_state_e s);
        return (s != RUN);
    endfunction

endpackage

// File: rtl/timer_counter_rtl_prescaler.sv
// Clock prescaler: emits a one-cycle step strobe every PRESCALE enabled cycles.
module prescaler_rtl #(
    parameter int PRESCALE = 1,
    parameter int PS_W     = $clog2(PRESCALE) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt_q;

    assign step = en && (cnt_q == LAST);

    // Enabled-cycle counter; clr holds it at zero outside an active run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (step) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + PS_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

endmodule

// File: rtl/timer_counter_rtl.sv
// Parametrised down-counter/timer with prescaler, pause, one-shot/auto-reload
// modes, synchronous clear and a registered single-cycle expire pulse.
module timer_counter_rtl
    import timer_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             expire
);

    localparam int PS_W = $clog2(PRESCALE) + 1;

    timer_state_e     state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             done_q;
    logic             expire_q;
    logic             ps_clr_s;
    logic             step_s;

    assign ps_clr_s = load | clear | is_idle_like(state_q);

    prescaler_rtl #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (ps_clr_s),
        .en   (en),
        .step (step_s)
    );

    // Timer FSM: priority clear > load > step; done mirrors the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b1;
            expire_q <= 1'b0;
        end else if (clear) begin
            state_q  <= IDLE;
            count_q  <= '0;
            done_q   <= 1'b1;
            expire_q <= 1'b0;
        end else if (load) begin
            if (in != '0) begin
                state_q  <= RUN;
                count_q  <= in;
                reload_q <= in;
                done_q   <= 1'b0;
                expire_q <= 1'b0;
            end else begin
                state_q  <= DONE;
                count_q  <= '0;
                done_q   <= 1'b1;
                expire_q <= 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (step_s) begin
                        if (count_q > WIDTH'(1)) begin
                            count_q  <= count_q - WIDTH'(1);
                            expire_q <= 1'b0;
                        end else if (auto_reload) begin
                            // Periodic mode jumps straight to the reload value, never showing 0.
                            count_q  <= reload_q;
                            expire_q <= 1'b1;
                        end else begin
                            state_q  <= DONE;
                            count_q  <= '0;
                            done_q   <= 1'b1;
                            expire_q <= 1'b1;
                        end
                    end else begin
                        expire_q <= 1'b0;
                    end
                end
                default: begin
                    expire_q <= 1'b0;
                end
            endcase
        end
    end

    assign count  = count_q;
    assign done   = done_q;
    assign expire = expire_q;

endmodule

// File: tb/tb_timer_counter_rtl.sv
// Scoreboard bench for timer_counter_rtl: two configurations share one stimulus stream.
module tb_timer_counter_rtl;

    typedef struct {
        int cnt;
        bit dn;
        bit ex;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        load;
    logic [15:0] in_v;
    logic        en;
    logic        auto_reload;
    logic [15:0] count_a;
    logic        done_a;
    logic        expire_a;
    logic [7:0]  count_b;
    logic        done_b;
    logic        expire_b;

    exp_t qa[$];
    exp_t qb[$];

    int m_cnt[2];
    int m_rel[2];
    int m_ps[2];
    int m_st[2];
    int pre[2]  = '{1, 4};
    int mask[2] = '{65535, 255};

    int total = 0;
    int bad   = 0;

    timer_counter_rtl #(.WIDTH(16), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .in(in_v),
        .en(en), .auto_reload(auto_reload),
        .count(count_a), .done(done_a), .expire(expire_a)
    );

    timer_counter_rtl #(.WIDTH(8), .PRESCALE(4)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .in(in_v[7:0]),
        .en(en), .auto_reload(auto_reload),
        .count(count_b), .done(done_b), .expire(expire_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_ps[i] = 0; m_st[i] = 0;
        end
    endfunction

    // Reference: states 0 idle, 1 run, 2 done; prescaler counts enabled cycles up to pre[i].
    function automatic exp_t model_step(int i, bit c, bit l, int v, bit e, bit ar);
        exp_t r;
        int   val;
        r.ex = 1'b0;
        if (c) begin
            m_cnt[i] = 0; m_st[i] = 0; m_ps[i] = 0;
        end else if (l) begin
            val = v & mask[i];
            m_ps[i] = 0;
            if (val != 0) begin
                m_cnt[i] = val; m_rel[i] = val; m_st[i] = 1;
            end else begin
                m_cnt[i] = 0; m_st[i] = 2; r.ex = 1'b1;
            end
        end else if (m_st[i] == 1 && e) begin
            m_ps[i]++;
            if (m_ps[i] == pre[i]) begin
                m_ps[i] = 0;
                if (m_cnt[i] > 1) begin
                    m_cnt[i]--;
                end else begin
                    r.ex = 1'b1;
                    if (ar) m_cnt[i] = m_rel[i];
                    else begin
                        m_cnt[i] = 0; m_st[i] = 2;
                    end
                end
            end
        end
        r.cnt = m_cnt[i];
        r.dn  = (m_st[i] != 1);
        return r;
    endfunction

    task automatic cycle(input bit c, input bit l, input int v, input bit e, input bit ar);
        @(negedge clk);
        clear = c; load = l; in_v = 16'(v); en = e; auto_reload = ar;
        qa.push_back(model_step(0, c, l, v, e, ar));
        qb.push_back(model_step(1, c, l, v, e, ar));
    endtask

    task automatic check_reset_now();
        check("rst_cnt_a", 32'(count_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd1);
        check("rst_exp_a", 32'(expire_a), 32'd0);
        check("rst_cnt_b", 32'(count_b), 32'd0);
        check("rst_done_b", 32'(done_b), 32'd1);
        check("rst_exp_b", 32'(expire_b), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear = 1'b0; load = 1'b0; en = 1'b0; auto_reload = 1'b0; in_v = 16'd0;
        rst = 1'b1;
        #1;
        check_reset_now();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares every registered output shortly after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                x = qa.pop_front();
                check("cnt_a", 32'(count_a), 32'(x.cnt));
                check("done_a", 32'(done_a), 32'(x.dn));
                check("exp_a", 32'(expire_a), 32'(x.ex));
            end
            if (qb.size() > 0) begin
                x = qb.pop_front();
                check("cnt_b", 32'(count_b), 32'(x.cnt));
                check("done_b", 32'(done_b), 32'(x.dn));
                check("exp_b", 32'(expire_b), 32'(x.ex));
            end
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0; auto_reload = 1'b0; in_v = 16'd0;
        #1;
        check_reset_now();
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        cycle(1'b0, 1'b1, 3, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);

        cycle(1'b0, 1'b1, 2, 1'b1, 1'b1);
        repeat (8) cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);

        cycle(1'b0, 1'b1, 2, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);

        cycle(1'b0, 1'b1, 5, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 7, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 9, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);

        cycle(1'b0, 1'b1, 0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);

        cycle(1'b0, 1'b1, 5, 1'b1, 1'b0);
        do_reset();

        repeat (3000) begin
            cycle(($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 6)),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)));
        end

        cycle(1'b0, 1'b1, 65535, 1'b1, 1'b0);
        repeat (65537) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
